// File: rtl/page_loader.sv
// page_loader: packs ingress FIFO bytes into two ping-pong pages with EEPROM addresses; optional PAGE_FLUSH_EN pads an idle partial page.
// Latency: first pop to page_valid is 130 cycles minimum; page_ack to page_valid low is 1 cycle; rd_idx to rd_data is 1 cycle.
// Backpressure: when both buffers are full the FSM stalls and stops popping until page_ack frees one.
module page_loader #(
    parameter int PAGE_BYTES   = 128,
    parameter int ADDR_W       = 17,
    parameter int FLUSH_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fifo_empty,
    input  logic [7:0]                    fifo_dout,
    output logic                          fifo_rd_en,
    output logic                          page_valid,
    output logic [ADDR_W-1:0]             page_addr,
    output logic                          page_last,
    output logic                          page_partial,
    input  logic                          page_ack,
    input  logic [$clog2(PAGE_BYTES)-1:0] rd_idx,
    output logic [7:0]                    rd_data
);
    localparam int IDX_W = $clog2(PAGE_BYTES);
    localparam logic [IDX_W:0]    CNT_FULL  = (IDX_W+1)'(PAGE_BYTES);
    localparam logic [IDX_W:0]    CNT_LAST  = (IDX_W+1)'(PAGE_BYTES - 1);
    localparam logic [ADDR_W-1:0] PAGE_STEP = ADDR_W'(PAGE_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ~ADDR_W'(PAGE_BYTES - 1);

    typedef enum logic [1:0] {FILL, PAD, COMMIT, STALL} state_t;

    state_t           state, state_nxt;
    logic [IDX_W:0]   issue_cnt, wr_cnt;
    logic             cap_vld, run, wr_sel, rd_sel;
    logic [1:0]       full;
    logic             pop, mem_we, do_ack;
    logic [7:0]       mem_wdat;
    logic [7:0]       mem [0:2*PAGE_BYTES-1];

`ifdef PAGE_FLUSH_EN
    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
    logic [FL_W-1:0]  idle_cnt;
    logic             flush_go;
    logic             padded;
    logic [1:0]       partial;

    assign flush_go     = (idle_cnt == FL_W'(FLUSH_CYCLES));
    assign page_partial = full[rd_sel] & partial[rd_sel];
`else
    assign page_partial = 1'b0;
`endif

    assign fifo_rd_en = pop;
    assign page_valid = full[rd_sel];
    assign page_last  = (page_addr == LAST_ADDR);
    assign do_ack     = page_ack && full[rd_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        mem_we    = 1'b0;
        mem_wdat  = fifo_dout;
        case (state)
            FILL: begin
                pop    = run && !fifo_empty && (issue_cnt < CNT_FULL)
`ifdef PAGE_FLUSH_EN
                         && !flush_go
`endif
                         ;
                mem_we = cap_vld;
                if (cap_vld && wr_cnt == CNT_LAST)
                    state_nxt = COMMIT;
`ifdef PAGE_FLUSH_EN
                else if (flush_go)
                    state_nxt = PAD;
`endif
            end
`ifdef PAGE_FLUSH_EN
            PAD: begin
                mem_we   = 1'b1;
                mem_wdat = 8'hFF;
                if (wr_cnt == CNT_LAST)
                    state_nxt = COMMIT;
            end
`endif
            COMMIT:  state_nxt = full[!wr_sel] ? STALL : FILL;
            STALL:   if (!full[wr_sel]) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            cap_vld   <= 1'b0;
            issue_cnt <= '0;
            wr_cnt    <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            full      <= '0;
            page_addr <= '0;
            rd_data   <= '0;
        end else begin
            run     <= 1'b1;
            cap_vld <= pop;
            rd_data <= mem[{rd_sel, rd_idx}];
            if (pop)    issue_cnt <= issue_cnt + 1'b1;
            if (mem_we) wr_cnt    <= wr_cnt + 1'b1;
            if (state == COMMIT) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
                issue_cnt    <= '0;
                wr_cnt       <= '0;
            end
            // The presented buffer is never the one being committed, so both updates coexist.
            if (do_ack) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
                page_addr    <= page_addr + PAGE_STEP;
            end
        end
    end

`ifdef PAGE_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            padded   <= 1'b0;
            partial  <= '0;
        end else begin
            if (pop || state != FILL)
                idle_cnt <= '0;
            else if (wr_cnt != '0 && !cap_vld && fifo_empty && !flush_go)
                idle_cnt <= idle_cnt + 1'b1;
            if (state == PAD)
                padded <= 1'b1;
            if (state == COMMIT) begin
                partial[wr_sel] <= padded;
                padded          <= 1'b0;
            end
        end
    end
`endif

    // Page storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[{wr_sel, wr_cnt[IDX_W-1:0]}] <= mem_wdat;
    end

endmodule

// File: tb/tb_page_loader.sv
// Bench for page_loader: behavioural non-FWFT FIFO source, byte scoreboard, table vectors.
// Address space is shrunk to 8 pages so the wrap is reached quickly.
module tb_page_loader;
    localparam int PB   = 128;
    localparam int AW   = 10;
    localparam int FC   = 16;
    localparam int LAST = (1 << AW) - PB;
    localparam int MASK = (1 << AW) - 1;

    typedef struct {
        logic [6:0] idx;
        logic [7:0] dat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fifo_empty;
    logic [7:0]    fifo_dout = 8'h00;
    logic          fifo_rd_en;
    logic          page_valid;
    logic [AW-1:0] page_addr;
    logic          page_last;
    logic          page_partial;
    logic          page_ack = 1'b0;
    logic [6:0]    rd_idx = 7'd0;
    logic [7:0]    rd_data;

    logic [7:0]    src_mem [0:4095];
    int            src_n = 0;
    int            src_rd = 0;
    int            underflow = 0;
    logic [7:0]    exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            exp_addr = 0;
    vec_t          vecs [6];

    page_loader #(.PAGE_BYTES(PB), .ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .page_valid(page_valid), .page_addr(page_addr),
        .page_last(page_last), .page_partial(page_partial), .page_ack(page_ack),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (src_rd == src_n);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (src_rd != src_n) begin
                fifo_dout <= src_mem[src_rd];
                src_rd    <= src_rd + 1;
            end else begin
                underflow <= underflow + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            src_mem[src_n] = 8'(base + i);
            exp_q.push_back(8'(base + i));
            src_n++;
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (!page_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("page_valid_wait", page_valid, 1);
    endtask

    task automatic read_page(input bit partial_exp);
        logic [7:0] e;
        check("page_addr", page_addr, exp_addr);
        check("page_last", page_last, (exp_addr == LAST) ? 1 : 0);
        check("page_partial", page_partial, partial_exp);
        for (int i = 0; i < PB; i++) begin
            rd_idx = 7'(i);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty: got byte 0x%0h at idx %0d with nothing expected", rd_data, i);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e);
            end
        end
    endtask

    task automatic do_ack();
        page_ack = 1'b1;
        @(negedge clk);
        page_ack = 1'b0;
        exp_addr = (exp_addr + PB) & MASK;
    endtask

    initial begin
        int cyc;
        int en_seen;

        vecs[0] = '{7'd5,   8'h05};
        vecs[1] = '{7'd0,   8'h00};
        vecs[2] = '{7'd127, 8'h7F};
        vecs[3] = '{7'd64,  8'h40};
        vecs[4] = '{7'd1,   8'h01};
        vecs[5] = '{7'd126, 8'h7E};

        #2 rst_n = 1'b0;
        #1;
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst_page_valid", page_valid, 0);
        check("rst_page_addr", page_addr, 0);
        check("rst_page_last", page_last, 0);
        check("rst_page_partial", page_partial, 0);
        check("rst_rd_data", rd_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First page: latency, table-driven reads, then full scoreboard read.
        push(PB, 0);
        wait_valid(200, cyc);
        check("first_page_latency", cyc, 130);
        for (int v = 0; v < 6; v++) begin
            rd_idx = vecs[v].idx;
            @(negedge clk);
            check("table_rd_data", rd_data, vecs[v].dat);
        end
        read_page(1'b0);
        do_ack();
        check("valid_after_ack", page_valid, 0);
        page_ack = 1'b1;
        @(negedge clk);
        page_ack = 1'b0;
        check("ignored_ack_addr", page_addr, exp_addr);

        // Both buffers fill, then the FSM stalls with bytes left in the FIFO.
        push(300, 128);
        repeat (450) @(negedge clk);
        check("stall_page_valid", page_valid, 1);
        check("fifo_left", src_n - src_rd, 44);
        en_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd_en) en_seen++;
        end
        check("stall_no_pop", en_seen, 0);

        read_page(1'b0);
        do_ack();
        check("addr_after_ack1", page_addr, exp_addr);
        check("valid_held_other_full", page_valid, 1);
        read_page(1'b0);
        do_ack();
        check("addr_after_ack2", page_addr, exp_addr);
        push(84, 428);
        wait_valid(400, cyc);
        read_page(1'b0);
        do_ack();

        // Partial page: padded when flushing is built in, otherwise held back.
        push(10, 8'hA0);
`ifdef PAGE_FLUSH_EN
        for (int i = 10; i < PB; i++) exp_q.push_back(8'hFF);
        wait_valid(400, cyc);
        read_page(1'b1);
        do_ack();
`else
        repeat (200) @(negedge clk);
        check("partial_held", page_valid, 0);
        push(PB - 10, 8'hAA);
        wait_valid(400, cyc);
        read_page(1'b0);
        do_ack();
`endif

        // Stream past the top page to exercise page_last and the address wrap.
        push(12 * PB, 8'h33);
        for (int p = 0; p < 12; p++) begin
            wait_valid(400, cyc);
            read_page(1'b0);
            do_ack();
        end
        check("addr_after_stream", page_addr, exp_addr);

        // Reset with one page presented and 60 bytes into the next.
        push(PB + 60, 8'h11);
        wait_valid(400, cyc);
        cyc = 0;
        while (src_rd != src_n && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_fill_popped", src_n - src_rd, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_page_valid", page_valid, 0);
        check("arst_page_addr", page_addr, 0);
        check("arst_page_last", page_last, 0);
        check("arst_page_partial", page_partial, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_fifo_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        exp_addr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push(PB, 8'h55);
        wait_valid(400, cyc);
        check("post_reset_latency", cyc, 130);
        read_page(1'b0);
        do_ack();

        check("fifo_underflow", underflow, 0);
        check("scoreboard_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/page_loader.md
# page_loader

Double-buffered page assembler between the UART ingress FIFO and the EEPROM page writer. It pops bytes from the FIFO, which has standard (non-FWFT) read timing, and packs them into 128-byte pages in two ping-pong buffers. It presents each completed page to the writer with a 17-bit page-aligned EEPROM address. The writer reads bytes by index and releases each page with `page_ack`.

## Interface
- `PAGE_BYTES`, 128: bytes per page; power of two.
- `ADDR_W`, 17: EEPROM address width.
- `FLUSH_CYCLES`, 4096: idle cycles before a partial page is padded; only used with `PAGE_FLUSH_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  ingress FIFO empty.
- `fifo_dout`  in  8  ingress FIFO data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  ingress FIFO pop.
- `page_valid`  out  1  a full page is presented.
- `page_addr`  out  `ADDR_W`  base address of the presented page; low 7 bits always 0.
- `page_last`  out  1  presented page is the top page, 0x1FF80.
- `page_partial`  out  1  presented page was completed by padding.
- `page_ack`  in  1  single-cycle pulse: writer is done with the presented page.
- `rd_idx`  in  7  byte index into the presented page.
- `rd_data`  out  8  byte at `rd_idx`; registered.

## Operation
- Two buffers of `PAGE_BYTES` x 8, each with a `full` flag. `wr_sel` selects the fill buffer and `rd_sel` the presented buffer. Both selects start at buffer 0.
- Fill FSM states: FILL, PAD, COMMIT, STALL.
- FILL:
  - Assert `fifo_rd_en` when `!fifo_empty` and `issue_cnt < PAGE_BYTES`; `issue_cnt` then increments.
  - One cycle after each pop, write `fifo_dout` to `buf[wr_sel][wr_cnt]` and increment `wr_cnt`.
  - Pops may issue back-to-back, one per cycle.
  - When the 128th byte is written, go to COMMIT.
- COMMIT (one cycle):
  - Set `full[wr_sel]` and copy the page's padded flag into that buffer's `partial` bit.
  - Toggle `wr_sel` and clear `issue_cnt`, `wr_cnt` and the padded flag.
  - Next state is STALL if the new `wr_sel` buffer is still full, else FILL.
- STALL: no pops; go to FILL once `full[wr_sel]` clears.
- Presentation:
  - `page_valid = full[rd_sel]`; `page_partial` is the `partial` bit of `rd_sel`.
  - `page_ack` while `page_valid` clears `full[rd_sel]`, toggles `rd_sel`, and advances `page_addr` by 128.
  - `page_addr` wraps from 0x1FF80 to 0x00000.
  - `page_ack` while `!page_valid` is ignored.
- `page_last = (page_addr == 0x1FF80)`.
- `rd_data <= buf[rd_sel][rd_idx]` every cycle, whether or not `page_valid` is high.
- Simultaneous COMMIT into one buffer and `page_ack` of the other buffer in the same cycle: both take effect.
- A buffer freed by `page_ack` can be refilled from the following cycle.

## Timing
- Reset values: `fifo_rd_en`=0, `page_valid`=0, `page_addr`=0, `page_last`=0, `page_partial`=0, `rd_data`=0.
- Reset also clears both `full` flags, both selects, all counters, and puts the FSM in FILL.
- Buffer contents are not reset.
- Reset mid-fill discards the partial page; the bytes already popped are lost.
- First byte popped to `page_valid` high: 128 pops + 1 capture cycle + 1 COMMIT cycle, so minimum 130 cycles from the first `fifo_rd_en`.
- `page_ack` to `page_valid` low: 1 cycle. If the other buffer is full, `page_valid` stays high and `page_addr` advances in that cycle.
- `rd_idx` to `rd_data`: 1 cycle.
- The writer must not change `rd_sel` by acking while it still reads; an ack takes effect on the next edge.
- `fifo_rd_en` never asserts while `fifo_empty`=1, in STALL, or once `issue_cnt`=128.

## Configuration
- `PAGE_FLUSH_EN` defined:
  - In FILL with `0 < wr_cnt < 128` and no pop outstanding, an idle counter increments each cycle `fifo_empty`=1 and clears on any pop.
  - When the idle counter reaches `FLUSH_CYCLES`, go to PAD.
  - PAD writes 0xFF at `wr_cnt`, one byte per cycle, and sets the padded flag. It issues no pops, then goes to COMMIT.
- `PAGE_FLUSH_EN` undefined: no idle counter and no PAD state. A partial page waits indefinitely, and `page_partial` is tied to 0.

## Test plan
- Push 0x00..0x7F; no ack -> `page_valid`=1, `page_addr`=0x00000, `page_partial`=0; `rd_idx`=5 returns `rd_data`=0x05 one cycle later.
- Push 300 bytes; no ack -> both buffers full; `fifo_rd_en` stays 0 after pop 256; 44 bytes remain in the FIFO.
- Then ack twice -> `page_addr` goes 0x00080 then 0x00100; filling resumes from byte 256.
- With `PAGE_FLUSH_EN` and `FLUSH_CYCLES`=16: push 10 bytes, then idle -> page presented with idx 0..9 equal to the data, idx 10..127 equal to 0xFF, and `page_partial`=1.
- Stream 1024 pages with immediate acks -> `page_last`=1 only while `page_addr`=0x1FF80; the next `page_addr` is 0x00000.
- Deassert `rst_n` after 60 bytes of a page -> all outputs return to reset values asynchronously. Afterwards a fresh 128 bytes produce a page at `page_addr` 0x00000.
